// File: rtl/image_writer_if.sv
// image_writer_if: pixel write port, byte stream output and status of the frame writer
interface image_writer_if;
  logic        WR_VALID;
  logic [11:0] WRITE_WIDTH;
  logic [11:0] WRITE_HEIGHT;
  logic [11:0] WRITE_ROW;
  logic [11:0] WRITE_COL;
  logic [7:0]  WRITE_RED;
  logic [7:0]  WRITE_GREEN;
  logic [7:0]  WRITE_BLUE;
  logic        BUSY;
  logic [7:0]  OUT_BYTE;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OUT_LAST;
  logic        DONE;
  logic [15:0] DROP_COUNT;
  modport slave (
    input  WR_VALID, WRITE_WIDTH, WRITE_HEIGHT, WRITE_ROW, WRITE_COL,
    input  WRITE_RED, WRITE_GREEN, WRITE_BLUE, OUT_READY,
    output BUSY, OUT_BYTE, OUT_VALID, OUT_LAST, DONE, DROP_COUNT
  );
  modport master (
    output WR_VALID, WRITE_WIDTH, WRITE_HEIGHT, WRITE_ROW, WRITE_COL,
    output WRITE_RED, WRITE_GREEN, WRITE_BLUE, OUT_READY,
    input  BUSY, OUT_BYTE, OUT_VALID, OUT_LAST, DONE, DROP_COUNT
  );
endinterface

// File: rtl/image_writer.sv
// image_writer: captures a randomly addressed RGB frame into RAM, then streams it out as B,G,R bytes
module image_writer #(
  parameter int MAX_WIDTH  = 128,
  parameter int MAX_HEIGHT = 128
) (
  input logic CLK,
  input logic RESET,
  image_writer_if.slave bus
);
  localparam int DEPTH = MAX_WIDTH * MAX_HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [23:0] mem [DEPTH];
  logic [11:0] w_q, h_q, cur_w, cur_h;
  logic [23:0] acc_q, acc_nx, total, rd_addr_q, rd_q, out_pix_q;
  logic [AW-1:0] wr_addr;
  logic [1:0]  idx_q;
  logic [15:0] drop_q;
  logic        pf_valid_q, pf_last_q, out_valid_q, last_pix_q, done_q;
  logic        dims_ok, store, drop, xfer, out_last, load, fetch;
  // While idle the incoming dimensions decide where the first pixel lands
  assign cur_w    = state_q == IDLE ? bus.WRITE_WIDTH : w_q;
  assign cur_h    = state_q == IDLE ? bus.WRITE_HEIGHT : h_q;
  assign dims_ok  = bus.WRITE_WIDTH != 12'd0 && bus.WRITE_WIDTH <= 12'(MAX_WIDTH) &&
                    bus.WRITE_HEIGHT != 12'd0 && bus.WRITE_HEIGHT <= 12'(MAX_HEIGHT);
  assign store    = bus.WR_VALID && bus.WRITE_ROW < cur_h && bus.WRITE_COL < cur_w &&
                    (state_q == CAPTURE || (state_q == IDLE && !done_q && dims_ok));
  assign drop     = bus.WR_VALID && !store;
  assign wr_addr  = AW'({12'd0, bus.WRITE_ROW} * {12'd0, cur_w} + {12'd0, bus.WRITE_COL});
  assign total    = {12'd0, w_q} * {12'd0, h_q};
  assign acc_nx   = state_q == IDLE ? 24'd1 : acc_q + 24'd1;
  assign xfer     = out_valid_q && bus.OUT_READY;
  assign out_last = out_valid_q && last_pix_q && idx_q == 2'd2;
  // A prefetched pixel moves to the output stage when the stage is empty or its red byte leaves
  assign load     = pf_valid_q && (!out_valid_q || (xfer && idx_q == 2'd2));
  assign fetch    = state_q == DRAIN && rd_addr_q < total && (!pf_valid_q || load);
  assign bus.BUSY       = state_q != IDLE;
  assign bus.OUT_BYTE   = idx_q == 2'd0 ? out_pix_q[7:0] : idx_q == 2'd1 ? out_pix_q[15:8] : out_pix_q[23:16];
  assign bus.OUT_VALID  = out_valid_q;
  assign bus.OUT_LAST   = out_last;
  assign bus.DONE       = done_q;
  assign bus.DROP_COUNT = drop_q;
  // State register
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) state_q <= IDLE;
    else state_q <= state_d;
  // Next state: a 1x1 frame is complete with its first pixel
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && store)
      state_d = bus.WRITE_WIDTH == 12'd1 && bus.WRITE_HEIGHT == 12'd1 ? DRAIN : CAPTURE;
    else if (state_q == CAPTURE && store && acc_nx == total)
      state_d = DRAIN;
    else if (state_q == DRAIN && xfer && out_last)
      state_d = IDLE;
  end
  // Frame RAM: not reset so a partial frame simply gets overwritten
  always_ff @(posedge CLK) begin
    if (store) mem[wr_addr] <= {bus.WRITE_RED, bus.WRITE_GREEN, bus.WRITE_BLUE};
    if (fetch) rd_q <= mem[rd_addr_q[AW-1:0]];
  end
  // Counters, latched dimensions, prefetch and output byte stage
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      w_q         <= '0;
      h_q         <= '0;
      acc_q       <= '0;
      rd_addr_q   <= '0;
      drop_q      <= '0;
      pf_valid_q  <= 1'b0;
      pf_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      idx_q       <= '0;
      last_pix_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (state_q == IDLE && store) begin
        w_q <= bus.WRITE_WIDTH;
        h_q <= bus.WRITE_HEIGHT;
      end
      if (store) acc_q <= acc_nx;
      if (fetch) begin
        rd_addr_q  <= rd_addr_q + 24'd1;
        pf_valid_q <= 1'b1;
        pf_last_q  <= rd_addr_q == total - 24'd1;
      end else if (load) pf_valid_q <= 1'b0;
      if (load) begin
        out_valid_q <= 1'b1;
        out_pix_q   <= rd_q;
        idx_q       <= 2'd0;
        last_pix_q  <= pf_last_q;
      end else if (xfer) begin
        if (idx_q == 2'd2) out_valid_q <= 1'b0;
        else idx_q <= idx_q + 2'd1;
      end
      if (xfer && out_last) begin
        done_q    <= 1'b1;
        acc_q     <= '0;
        rd_addr_q <= '0;
      end
    end
endmodule

// File: tb/tb_image_writer.sv
// tb_image_writer: directed checks of frame capture, byte streaming, drops and reset
module tb_image_writer;
  logic CLK, RESET;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] got[$], exq[$];
  int last_pos, last_cnt, first_cyc, span;
  logic [95:0] e22 = 96'h302000_302001_30200A_30200B;
  image_writer_if bus();
  image_writer dut (.CLK(CLK), .RESET(RESET), .bus(bus.slave));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wr(input int w, input int h, input int r, input int c,
                    input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    bus.WRITE_WIDTH = 12'(w);
    bus.WRITE_HEIGHT = 12'(h);
    bus.WRITE_ROW = 12'(r);
    bus.WRITE_COL = 12'(c);
    bus.WRITE_RED = rr;
    bus.WRITE_GREEN = gg;
    bus.WRITE_BLUE = bb;
    bus.WR_VALID = 1'b1;
    tick();
    bus.WR_VALID = 1'b0;
  endtask

  task automatic set_exp2x2();
    exq.delete();
    for (int i = 0; i < 12; i++) exq.push_back(e22[95-8*i -: 8]);
  endtask

  task automatic drain(input logic [3:0] pat, input int stop_n, input int limit);
    int cyc;
    bit stall, fin;
    logic [7:0] sb;
    logic sl;
    got.delete();
    last_pos = -1; last_cnt = 0; first_cyc = -1; span = 0;
    cyc = 0; stall = 0; fin = 0; sb = 0; sl = 0;
    while (!fin && cyc < limit) begin
      bus.OUT_READY = pat[2'(cyc)];
      if (stall) begin
        chk("stall_valid", bus.OUT_VALID, 1);
        chk("stall_byte", bus.OUT_BYTE, sb);
        chk("stall_last", bus.OUT_LAST, sl);
      end
      stall = bus.OUT_VALID && !bus.OUT_READY;
      sb = bus.OUT_BYTE;
      sl = bus.OUT_LAST;
      if (bus.OUT_VALID && first_cyc < 0) first_cyc = cyc;
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (bus.OUT_LAST) begin
          last_pos = got.size();
          last_cnt++;
          fin = 1;
        end
        got.push_back(bus.OUT_BYTE);
        if (stop_n != 0 && got.size() == stop_n) fin = 1;
        span = cyc - first_cyc + 1;
      end
      tick();
      cyc++;
    end
    bus.OUT_READY = 1'b0;
    chk("drain_in_time", fin, 1);
    if (last_cnt > 0) chk("done_pulse", bus.DONE, 1);
  endtask

  task automatic chk_frame();
    chk("frame_len", got.size(), exq.size());
    for (int i = 0; i < exq.size() && i < got.size(); i++) chk("frame_byte", got[i], exq[i]);
    chk("last_pos", last_pos, exq.size() - 1);
    chk("last_cnt", last_cnt, 1);
  endtask

  task automatic after_done(input int drops);
    tick();
    chk("done_clear", bus.DONE, 0);
    chk("idle_busy", bus.BUSY, 0);
    chk("drop_count", bus.DROP_COUNT, drops);
  endtask

  initial begin
    bus.WR_VALID = 0; bus.OUT_READY = 0;
    bus.WRITE_WIDTH = 0; bus.WRITE_HEIGHT = 0; bus.WRITE_ROW = 0; bus.WRITE_COL = 0;
    bus.WRITE_RED = 0; bus.WRITE_GREEN = 0; bus.WRITE_BLUE = 0;
    RESET = 1'b1;
    #3 RESET = 1'b0;
    tick(); tick();
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_valid", bus.OUT_VALID, 0);
    chk("rst_last", bus.OUT_LAST, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_byte", bus.OUT_BYTE, 0);
    chk("rst_drop", bus.DROP_COUNT, 0);
    RESET = 1'b1;
    // 2x2 raster order, always ready
    wr(2, 2, 0, 0, 8'h00, 8'h20, 8'h30);
    chk("busy_capture", bus.BUSY, 1);
    wr(2, 2, 0, 1, 8'h01, 8'h20, 8'h30);
    wr(2, 2, 1, 0, 8'h0A, 8'h20, 8'h30);
    wr(2, 2, 1, 1, 8'h0B, 8'h20, 8'h30);
    set_exp2x2();
    drain(4'b1111, 0, 100);
    chk_frame();
    chk("span_raster", span, 12);
    after_done(0);
    // 2x2 reverse order
    wr(2, 2, 1, 1, 8'h0B, 8'h20, 8'h30);
    wr(2, 2, 1, 0, 8'h0A, 8'h20, 8'h30);
    wr(2, 2, 0, 1, 8'h01, 8'h20, 8'h30);
    wr(2, 2, 0, 0, 8'h00, 8'h20, 8'h30);
    drain(4'b1111, 0, 100);
    chk_frame();
    after_done(0);
    // 2x2 with ready pattern 1,0,0,1
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) wr(2, 2, r, c, 8'(10*r + c), 8'h20, 8'h30);
    drain(4'b1001, 0, 200);
    chk_frame();
    after_done(0);
    // 3x2 with an out-of-range row injected, then a zero-width pixel
    exq.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) begin
        if (r == 0 && c == 2) wr(3, 2, 5, 1, 8'hEE, 8'hEE, 8'hEE);
        wr(3, 2, r, c, 8'(16*r + c + 1), 8'h55, 8'(8'hA0 + r));
        exq.push_back(8'(8'hA0 + r));
        exq.push_back(8'h55);
        exq.push_back(8'(16*r + c + 1));
      end
    chk("drop_row5", bus.DROP_COUNT, 1);
    drain(4'b1111, 0, 100);
    chk_frame();
    after_done(1);
    wr(0, 2, 0, 0, 8'h11, 8'h22, 8'h33);
    chk("drop_w0", bus.DROP_COUNT, 2);
    chk("w0_idle", bus.BUSY, 0);
    // reset in the middle of a drain
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) wr(2, 2, r, c, 8'(10*r + c), 8'h20, 8'h30);
    drain(4'b1111, 4, 100);
    chk("part_len", got.size(), 4);
    chk("part_b3", got[3], 8'h30);
    #2 RESET = 1'b0;
    #1;
    chk("mid_rst_valid", bus.OUT_VALID, 0);
    chk("mid_rst_busy", bus.BUSY, 0);
    chk("mid_rst_drop", bus.DROP_COUNT, 0);
    chk("mid_rst_byte", bus.OUT_BYTE, 0);
    tick();
    RESET = 1'b1;
    wr(1, 1, 0, 0, 8'h01, 8'h02, 8'h03);
    chk("first_after_rst", bus.BUSY, 1);
    drain(4'b1111, 0, 50);
    exq.delete();
    exq.push_back(8'h03); exq.push_back(8'h02); exq.push_back(8'h01);
    chk_frame();
    chk("first_valid_lat", first_cyc, 2);
    // a pixel arriving with DONE is dropped, the next one starts a frame
    wr(1, 1, 0, 0, 8'h09, 8'h09, 8'h09);
    chk("done_cycle_drop", bus.DROP_COUNT, 1);
    chk("done_cycle_idle", bus.BUSY, 0);
    wr(1, 1, 0, 0, 8'h07, 8'h08, 8'h09);
    chk("next_frame_busy", bus.BUSY, 1);
    drain(4'b1111, 0, 50);
    exq.delete();
    exq.push_back(8'h09); exq.push_back(8'h08); exq.push_back(8'h07);
    chk_frame();
    after_done(1);
    // oversized width, then a full-size frame
    wr(129, 1, 0, 0, 8'h01, 8'h01, 8'h01);
    chk("drop_w129", bus.DROP_COUNT, 2);
    chk("w129_idle", bus.BUSY, 0);
    exq.delete();
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++) begin
        logic [13:0] a;
        a = 14'(r*128 + c);
        wr(128, 128, r, c, 8'h5A ^ a[7:0], {2'b00, a[13:8]}, a[7:0]);
        exq.push_back(a[7:0]);
        exq.push_back({2'b00, a[13:8]});
        exq.push_back(8'h5A ^ a[7:0]);
      end
    drain(4'b1111, 0, 49152 + 100);
    chk_frame();
    chk("span_full", span, 49152);
    after_done(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/image_writer.md
IMAGE_WRITER -- requirements
Module: image_writer

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 128, largest accepted frame width in pixels.
REQ-002 SHALL have parameter MAX_HEIGHT, default 128, largest accepted frame height in pixels.
REQ-003 SHALL have CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have WR_VALID  input  1  pixel on WRITE_* valid this cycle.
REQ-006 SHALL have WRITE_WIDTH, WRITE_HEIGHT  input  12 each  frame dimensions.
REQ-007 SHALL have WRITE_ROW, WRITE_COL  input  12 each  pixel destination coordinates.
REQ-008 SHALL have WRITE_RED, WRITE_GREEN, WRITE_BLUE  input  8 each  pixel colour.
REQ-009 SHALL have BUSY  output  1  high in CAPTURE or DRAIN.
REQ-010 SHALL have OUT_BYTE  output  8  serialized frame byte.
REQ-011 SHALL have OUT_VALID  output  1  OUT_BYTE valid.
REQ-012 SHALL have OUT_READY  input  1  downstream accepts OUT_BYTE.
REQ-013 SHALL have OUT_LAST  output  1  marks the final byte of a frame.
REQ-014 SHALL have DONE  output  1  one-cycle pulse after the last byte is accepted.
REQ-015 SHALL have DROP_COUNT  output  16  saturating count of rejected pixels.

Function
REQ-016 SHALL implement states IDLE, CAPTURE, DRAIN.
REQ-017 IDLE: first WR_VALID pixel with 1<=WIDTH<=MAX_WIDTH and 1<=HEIGHT<=MAX_HEIGHT SHALL latch W/H, store that pixel, and enter CAPTURE; otherwise it is dropped and the state stays IDLE.
REQ-018 Store: pixel SHALL go to the internal frame memory at address ROW*W+COL using the latched W; the memory holds 24 bits per entry and MAX_WIDTH*MAX_HEIGHT entries.
REQ-019 CAPTURE: pixel with ROW>=H or COL>=W SHALL be dropped, not stored, and not counted.
REQ-020 Every stored pixel, including overwrites of the same address, SHALL increment the 24-bit accept counter.
REQ-021 Accept counter reaching W*H SHALL cause CAPTURE->DRAIN on the next edge; the W=H=1 frame enters DRAIN directly from IDLE.
REQ-022 WR_VALID in DRAIN SHALL be dropped.
REQ-023 Every dropped pixel SHALL increment DROP_COUNT, saturating at 16'hFFFF.
REQ-024 DRAIN SHALL emit addresses 0..W*H-1 in ascending order, 3 bytes per pixel in order BLUE, GREEN, RED.
REQ-025 Memory read SHALL be synchronous; first OUT_VALID SHALL assert exactly 2 cycles after entering DRAIN.
REQ-026 A byte SHALL transfer on an edge where OUT_VALID and OUT_READY are both high.
REQ-027 While OUT_VALID is high and OUT_READY is low, OUT_BYTE and OUT_LAST SHALL hold stable.
REQ-028 OUT_VALID SHALL not drop until transfer; one byte per cycle SHALL be sustained when OUT_READY is held high.
REQ-029 OUT_LAST SHALL be high only with the RED byte of address W*H-1.
REQ-030 Transfer of the OUT_LAST byte SHALL pulse DONE on the next cycle and return to IDLE, clearing the accept counter.
REQ-031 DROP_COUNT SHALL persist across frames.
REQ-032 WR_VALID in the same cycle as the DONE pulse SHALL be dropped; the next frame starts from IDLE the following cycle.

Reset
REQ-033 On RESET low, state SHALL go IDLE immediately, including mid-CAPTURE or mid-DRAIN, discarding the partial frame.
REQ-034 On RESET low, BUSY=0, OUT_VALID=0, OUT_LAST=0, DONE=0, OUT_BYTE=8'h00, DROP_COUNT=0, and counters and latched W/H cleared.
REQ-035 Frame memory contents SHALL not be cleared by reset.
REQ-036 First valid input SHALL be accepted on the first rising edge after RESET deasserts.

Verification
REQ-037 2x2 frame, raster order, pixel (r,c) RGB=(10r+c, 0x20, 0x30), OUT_READY=1 -> 12 bytes 30,20,00,30,20,01,30,20,0A,30,20,0B; OUT_LAST on 12th; DONE one cycle later.
REQ-038 Same 2x2 frame written in reverse order (1,1),(1,0),(0,1),(0,0) -> identical 12-byte output.
REQ-039 OUT_READY toggling 1,0,0,1 repeating -> byte sequence unchanged, OUT_BYTE stable during stalls, no byte lost or duplicated.
REQ-040 During a 3x2 capture, inject ROW=5 pixel, then a WIDTH=0 pixel while IDLE after DONE -> DROP_COUNT=2, output unaffected.
REQ-041 RESET low after 4th byte of a 2x2 drain -> OUT_VALID=0 and BUSY=0 immediately; a following 1x1 frame RGB=(1,2,3) -> bytes 03,02,01 with OUT_LAST on 01.
REQ-042 MAX_WIDTH x MAX_HEIGHT frame -> exactly 3*MAX_WIDTH*MAX_HEIGHT bytes; a 129-wide pixel at default parameters is dropped.
